if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Fetch stage of the LC-3b pipeline, directly upstream of the IF/ID register.
- Owns the PC register and drives the instruction-memory request/response handshake.
- Produces the PC+2 value, the instruction word and the IF/ID load enable.
- Holds fetched instructions across downstream stalls, discards wrong-path fetches on redirect, and inserts NOP bubbles into IF/ID when no valid instruction is available.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0000, bubble instruction (BR never) written into IF/ID.

Ports:
clk  input  1  pipeline clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
stall_in  input  1  IF/ID must hold; from the hazard unit.
redirect_valid  input  1  taken branch, jump or trap resolved downstream.
redirect_target  input  16  new PC; bit 0 is forced to 0.
imem_read  output  1  instruction-memory request.
imem_address  output  16  fetch address; always equals PC.
imem_resp  input  1  one-cycle response strobe; imem_rdata is valid in that cycle.
imem_rdata  input  16  instruction word from memory.
if_plus2_out  output  16  PC+2 of the delivered instruction; feeds IF/ID.
if_instr_out  output  16  instruction or NOP_INSTR; feeds IF/ID.
if_id_load  output  1  load enable for the IF/ID flops.

Behaviour:
- Registered state:
  - pc: 16 bits, resets to RESET_PC.
  - state: FETCH/HOLD/DISCARD, resets to FETCH.
  - hold_buf: 16 bits, resets to 0.
  - redirect_pc: 16 bits, resets to 0.
- Output reset values: all outputs combinational. Under reset: imem_read=0, imem_address=RESET_PC, if_id_load=1, if_instr_out=NOP_INSTR, if_plus2_out=RESET_PC.
- Memory protocol:
  - imem_read is high in FETCH and DISCARD, low in HOLD.
  - imem_address stays stable until imem_resp.
  - A new address may be presented in the cycle after a response.
- Delivery cycle: an instruction is delivered when if_id_load=1 and if_instr_out=instruction; then if_plus2_out=pc+2 and pc<=pc+2.
- Bubble cycle: if_id_load = redirect_valid | ~stall_in. In any load cycle without delivery, if_instr_out=NOP_INSTR and if_plus2_out=pc.
- Redirect priority:
  - redirect_valid overrides stall_in: forces a bubble into IF/ID that cycle.
  - A same-cycle imem_resp is discarded.
- FETCH:
  - redirect_valid & imem_resp: pc<=redirect_target; stay FETCH.
  - redirect_valid & ~imem_resp: redirect_pc<=redirect_target; go to DISCARD.
  - imem_resp & ~stall_in: deliver imem_rdata (zero added latency); stay FETCH.
  - imem_resp & stall_in: hold_buf<=imem_rdata; go to HOLD.
  - Otherwise: wait, bubble if ~stall_in.
- HOLD:
  - redirect_valid: drop hold_buf; pc<=redirect_target; go to FETCH.
  - ~stall_in: deliver hold_buf; go to FETCH.
  - Otherwise: hold; if_id_load=0.
- DISCARD:
  - Additional redirect_valid overwrites redirect_pc (latest wins).
  - On imem_resp: data dropped; pc<=(redirect_valid ? redirect_target : redirect_pc); go to FETCH.
  - No delivery while in DISCARD.
- Arithmetic: pc+2 is modulo 2^16, so 16'hFFFE wraps to 16'h0000.
- Reset mid-operation: an outstanding request is abandoned. imem_read drops immediately (asynchronous) and the response is ignored.
- Throughput: one instruction per response; a response arriving on back-to-back cycles sustains 1 IPC.

Test Plan:
1. Reset release, memory responds the cycle after each request, stall_in=0 -> addresses 0x0000, 0x0002, 0x0004; IF/ID receives rdata with plus2 0x0002, 0x0004, 0x0006.
2. Response arrives with stall_in=1 for 3 cycles, rdata=0x1234 -> state HOLD, imem_read=0, if_id_load=0 for 3 cycles; then 0x1234 delivered with plus2=pc+2.
3. Redirect to 0x3001 while a request is outstanding, response arrives 2 cycles later -> next address 0x3000; stale data never loaded; NOP loaded in the redirect cycle.
4. Redirect to 0x4000 in the same cycle as imem_resp -> data dropped, NOP into IF/ID, next address 0x4000.
5. pc=0xFFFE, response delivered -> if_plus2_out=0x0000; next address 0x0000.
6. rst_n pulled low mid-request -> imem_read=0 immediately; after release, address equals RESET_PC and outputs hold their reset values.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and
// instruction memory.
//   imem_read    : fetch request, held high until a response arrives
//   imem_address : fetch address, stable while a request is outstanding
//   imem_resp    : single-cycle response strobe
//   imem_rdata   : instruction word, valid in the imem_resp cycle
// master = fetch unit, slave = instruction memory.
interface if_fetch_unit_if;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp;
    logic [15:0] imem_rdata;

    modport master (
        output imem_read,
        output imem_address,
        input  imem_resp,
        input  imem_rdata
    );

    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_resp,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// LC-3b fetch stage, feeding the IF/ID register.
// Owns the PC, runs the instruction-memory handshake, holds a fetched word
// across downstream stalls, drops wrong-path fetches after a redirect and
// inserts NOP bubbles into IF/ID when nothing valid is available.
// Ports:
//   clk, rst_n        : pipeline clock, async active-low reset
//   stall_in          : IF/ID must hold (hazard unit)
//   redirect_valid    : taken branch/jump/trap resolved downstream
//   redirect_target   : new PC (bit 0 forced to 0)
//   imem              : instruction-memory bundle (master side)
//   if_plus2_out      : PC+2 of the delivered instruction (PC on bubbles)
//   if_instr_out      : delivered instruction or NOP_INSTR
//   if_id_load        : IF/ID load enable
//
// state   | meaning
// FETCH   | request outstanding at pc; deliver on response
// HOLD    | response captured in hold_buf while IF/ID stalled; no request
// DISCARD | wrong-path request outstanding; drop its data, then go to redirect_pc
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_in,
    input  logic                   redirect_valid,
    input  logic [15:0]            redirect_target,
    if_fetch_unit_if.master        imem,
    output logic [15:0]            if_plus2_out,
    output logic [15:0]            if_instr_out,
    output logic                   if_id_load
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] hold_buf;
    logic [15:0] redirect_pc;

    logic [15:0] pc_plus2;
    logic [15:0] target_aligned;
    logic        deliver;

    assign pc_plus2       = pc + 16'd2;
    assign target_aligned = redirect_target & 16'hFFFE;

    // A redirect always wins over a delivery in the same cycle.
    assign deliver = rst_n && !redirect_valid && !stall_in &&
                     ((state == FETCH && imem.imem_resp) || state == HOLD);

    // rst_n is folded in so the request drops the instant reset asserts.
    assign imem.imem_read    = rst_n && (state != HOLD);
    assign imem.imem_address = pc;

    assign if_id_load   = !rst_n || redirect_valid || !stall_in;
    assign if_instr_out = deliver ? ((state == HOLD) ? hold_buf : imem.imem_rdata)
                                  : NOP_INSTR;
    assign if_plus2_out = deliver ? pc_plus2 : pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            hold_buf    <= 16'h0000;
            redirect_pc <= 16'h0000;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_valid && imem.imem_resp) begin
                        pc <= target_aligned;
                    end else if (redirect_valid) begin
                        redirect_pc <= target_aligned;
                        state       <= DISCARD;
                    end else if (imem.imem_resp && !stall_in) begin
                        pc <= pc_plus2;
                    end else if (imem.imem_resp) begin
                        hold_buf <= imem.imem_rdata;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc    <= target_aligned;
                        state <= FETCH;
                    end else if (!stall_in) begin
                        pc    <= pc_plus2;
                        state <= FETCH;
                    end
                end
                DISCARD: begin
                    if (imem.imem_resp) begin
                        pc    <= redirect_valid ? target_aligned : redirect_pc;
                        state <= FETCH;
                    end else if (redirect_valid) begin
                        redirect_pc <= target_aligned;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset values, sequential fetch,
// stall hold, redirect with outstanding request, redirect on response,
// PC wrap and asynchronous reset mid-request.
module tb_if_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        stall_in;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] if_plus2_out;
    logic [15:0] if_instr_out;
    logic        if_id_load;

    int errors;
    int checks;

    if_fetch_unit_if mem_bus ();

    if_fetch_unit #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_in        (stall_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem            (mem_bus.master),
        .if_plus2_out    (if_plus2_out),
        .if_instr_out    (if_instr_out),
        .if_id_load      (if_id_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a rising edge, then move to the falling edge for checks.
    task automatic step(input logic redir, input logic [15:0] tgt, input logic stall,
                        input logic resp, input logic [15:0] rdata);
        @(posedge clk);
        #1;
        redirect_valid       = redir;
        redirect_target      = tgt;
        stall_in             = stall;
        mem_bus.imem_resp    = resp;
        mem_bus.imem_rdata   = rdata;
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        stall_in = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 16'h0000;
        mem_bus.imem_resp = 1'b0;
        mem_bus.imem_rdata = 16'h0000;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_read", 16'(mem_bus.imem_read), 16'h0);
        chk("rst_addr", mem_bus.imem_address, 16'h0000);
        chk("rst_load", 16'(if_id_load), 16'h1);
        chk("rst_instr", if_instr_out, 16'h0000);
        chk("rst_plus2", if_plus2_out, 16'h0000);

        // 1. Sequential fetch, response one cycle after each request
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("t1_read0", 16'(mem_bus.imem_read), 16'h1);
        chk("t1_addr0", mem_bus.imem_address, 16'h0000);
        chk("t1_bubble_instr", if_instr_out, 16'h0000);
        chk("t1_bubble_plus2", if_plus2_out, 16'h0000);
        step(1'b0, 16'h0, 1'b0, 1'b1, 16'hA000);
        chk("t1_load0", 16'(if_id_load), 16'h1);
        chk("t1_instr0", if_instr_out, 16'hA000);
        chk("t1_plus2_0", if_plus2_out, 16'h0002);
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("t1_addr1", mem_bus.imem_address, 16'h0002);
        chk("t1_bubble1_plus2", if_plus2_out, 16'h0002);
        step(1'b0, 16'h0, 1'b0, 1'b1, 16'hA002);
        chk("t1_instr1", if_instr_out, 16'hA002);
        chk("t1_plus2_1", if_plus2_out, 16'h0004);
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("t1_addr2", mem_bus.imem_address, 16'h0004);
        step(1'b0, 16'h0, 1'b0, 1'b1, 16'hA004);
        chk("t1_instr2", if_instr_out, 16'hA004);
        chk("t1_plus2_2", if_plus2_out, 16'h0006);

        // 2. Response under stall -> HOLD for 3 cycles, then delivery
        step(1'b0, 16'h0, 1'b1, 1'b1, 16'h1234);
        chk("t2_addr", mem_bus.imem_address, 16'h0006);
        chk("t2_resp_load", 16'(if_id_load), 16'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
            chk("t2_hold_read", 16'(mem_bus.imem_read), 16'h0);
            chk("t2_hold_load", 16'(if_id_load), 16'h0);
        end
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("t2_load", 16'(if_id_load), 16'h1);
        chk("t2_instr", if_instr_out, 16'h1234);
        chk("t2_plus2", if_plus2_out, 16'h0008);

        // 3. Redirect with request outstanding, response 2 cycles later
        step(1'b1, 16'h3001, 1'b0, 1'b0, 16'h0);
        chk("t3_addr", mem_bus.imem_address, 16'h0008);
        chk("t3_redir_load", 16'(if_id_load), 16'h1);
        chk("t3_redir_instr", if_instr_out, 16'h0000);
        chk("t3_redir_plus2", if_plus2_out, 16'h0008);
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("t3_disc_read", 16'(mem_bus.imem_read), 16'h1);
        chk("t3_disc_addr", mem_bus.imem_address, 16'h0008);
        step(1'b0, 16'h0, 1'b0, 1'b1, 16'hDEAD);
        chk("t3_stale_instr", if_instr_out, 16'h0000);
        chk("t3_stale_plus2", if_plus2_out, 16'h0008);
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("t3_new_addr", mem_bus.imem_address, 16'h3000);
        chk("t3_new_read", 16'(mem_bus.imem_read), 16'h1);

        // 4. Redirect in the same cycle as a response
        step(1'b1, 16'h4000, 1'b0, 1'b1, 16'hBEEF);
        chk("t4_load", 16'(if_id_load), 16'h1);
        chk("t4_instr", if_instr_out, 16'h0000);
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("t4_new_addr", mem_bus.imem_address, 16'h4000);

        // 5. PC wrap: land on 0xFFFE via same-cycle redirect, then deliver
        step(1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h0);
        step(1'b0, 16'h0, 1'b0, 1'b1, 16'h5555);
        chk("t5_addr", mem_bus.imem_address, 16'hFFFE);
        chk("t5_instr", if_instr_out, 16'h5555);
        chk("t5_plus2", if_plus2_out, 16'h0000);
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("t5_wrap_addr", mem_bus.imem_address, 16'h0000);

        // 6. Async reset mid-request
        step(1'b0, 16'h0, 1'b0, 1'b1, 16'h7777);
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("t6_pre_addr", mem_bus.imem_address, 16'h0002);
        chk("t6_pre_read", 16'(mem_bus.imem_read), 16'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_read", 16'(mem_bus.imem_read), 16'h0);
        chk("t6_async_addr", mem_bus.imem_address, 16'h0000);
        step(1'b0, 16'h0, 1'b0, 1'b1, 16'h9999);
        chk("t6_rst_instr", if_instr_out, 16'h0000);
        chk("t6_rst_load", 16'(if_id_load), 16'h1);
        mem_bus.imem_resp = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rel_addr", mem_bus.imem_address, 16'h0000);
        chk("t6_rel_read", 16'(mem_bus.imem_read), 16'h1);
        chk("t6_rel_instr", if_instr_out, 16'h0000);
        chk("t6_rel_plus2", if_plus2_out, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end
endmodule
